frog_game_ctrl: RTL and testbench
=================================

FROG_GAME_CTRL -- requirements
Module: frog_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_BASE, default 128, PLAY-state clock cycles per drift tick at level 0.
REQ-002 SHALL have parameter LIVES, default 3 (legal range 1-3), lives loaded at game start.
REQ-003 SHALL have parameter HIT_HOLD, default 16, cycles the display is blanked after a crash.
REQ-004 clock  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level-sensitive start request, sampled every cycle.
REQ-007 crash  input  1  collision flag from the lane/frog logic.
REQ-008 goal  input  1  frog has reached the top row.
REQ-009 drift_tick  output  1  one-cycle pulse that advances lane drift.
REQ-010 lane_reset  output  1  one-cycle pulse that re-homes the frog and lanes.
REQ-011 blank  output  1  forces the matrix planes to zero.
REQ-012 lives  output  2  remaining lives.
REQ-013 level  output  2  current level, 0-3.
REQ-014 state  output  2  FSM state: IDLE=00, PLAY=01, HIT=10, OVER=11.
REQ-015 win  output  1  set when the game ended by clearing level 3.

Function
REQ-016 All outputs SHALL be registered; every response appears on the edge after the causing input is sampled.
REQ-017 IDLE: start=1 -> PLAY; lives=LIVES; level=0; win=0; tick counter=0; lane_reset pulses 1 cycle.
REQ-018 PLAY: tick counter increments each cycle; at count==period-1, drift_tick pulses 1 cycle and the counter wraps to 0.
REQ-019 The tick counter SHALL hold at 0 in every state other than PLAY, and drift_tick SHALL be 0 there.
REQ-020 PLAY, crash=1 -> HIT; lives decrements by 1 (saturates at 0); blank=1; hold counter=0.
REQ-021 PLAY, goal=1, crash=0, level<3 -> stay in PLAY; level increments by 1; tick counter=0; lane_reset pulses.
REQ-022 PLAY, goal=1, crash=0, level==3 -> OVER; win=1; level holds at 3.
REQ-023 If crash and goal are both asserted in the same cycle, crash SHALL take priority and goal is ignored.
REQ-024 HIT: blank stays 1 for exactly HIT_HOLD cycles; crash and goal are ignored.
REQ-025 HIT exit with lives>0: -> PLAY; blank=0; tick counter=0; lane_reset pulses.
REQ-026 HIT exit with lives==0: -> OVER; blank=1; win=0.
REQ-027 OVER: holds all outputs; start=1 behaves exactly as start in IDLE (REQ-017) and goes directly to PLAY.
REQ-028 crash and goal SHALL have no effect in IDLE and OVER.
REQ-029 lane_reset and drift_tick SHALL never be asserted in the same cycle; tick counter restart takes precedence.

Reset
REQ-030 Reset SHALL force: state=IDLE, lives=LIVES, level=0, win=0, blank=0, drift_tick=0, lane_reset=0, all counters=0.
REQ-031 Reset SHALL override every other input in the same cycle, including mid-HIT and mid-tick.

Configuration
REQ-032 With macro FROG_SPEEDUP_EN defined: period = TICK_BASE >> level, with a minimum of 16 (level 0..3 -> 128, 64, 32, 16 at default).
REQ-033 With FROG_SPEEDUP_EN undefined: period = TICK_BASE at every level; all other behaviour is unchanged.

Verification
REQ-034 Reset, then start for 1 cycle -> state=01, lives=3, level=0, lane_reset high for exactly 1 cycle.
REQ-035 In PLAY, level 0, no inputs -> drift_tick pulses every 128 cycles; with FROG_SPEEDUP_EN at level 2 -> pulses every 32 cycles.
REQ-036 Crash and goal together in PLAY -> state=10, lives=2, level unchanged, blank=1 for 16 cycles, then state=01 and lane_reset pulses.
REQ-037 Three crashes -> after the third HIT, state=11, lives=0, win=0, blank=1; a following start -> state=01, lives=3.
REQ-038 Four goals with no crash -> level steps 1, 2, 3, then state=11 with win=1; reset asserted mid-HIT -> all outputs return to REQ-030 values on the next edge.

Source files
------------

// File: rtl/frog_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frog_game_ctrl
//  Brief    : Game-flow controller for the frog/lane matrix game. Sequences
//             IDLE -> PLAY -> HIT/OVER, keeps lives and level, generates the
//             lane drift tick and the frog/lane re-home pulse. All outputs
//             are registered.
//  Options  : FROG_SPEEDUP_EN - when defined, the drift period halves with
//             each level (TICK_BASE >> level), floored at 16 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module frog_game_ctrl #(
    parameter int TICK_BASE = 128,
    parameter int LIVES     = 3,
    parameter int HIT_HOLD  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       crash,
    input  logic       goal,
    output logic       drift_tick,
    output logic       lane_reset,
    output logic       blank,
    output logic [1:0] lives,
    output logic [1:0] level,
    output logic [1:0] state,
    output logic       win
);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_PLAY = 2'b01;
    localparam logic [1:0] c_HIT  = 2'b10;
    localparam logic [1:0] c_OVER = 2'b11;

    // Counter wide enough for the largest period, including the 16-cycle floor
    localparam int c_PMAX   = (TICK_BASE > 16) ? TICK_BASE : 16;
    localparam int c_CNT_W  = $clog2(c_PMAX);
    localparam int c_HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

    localparam logic [c_CNT_W:0]    c_BASE      = (c_CNT_W + 1)'(TICK_BASE);
    localparam logic [c_CNT_W:0]    c_MINP      = (c_CNT_W + 1)'(16);
    localparam logic [c_CNT_W:0]    c_PONE      = (c_CNT_W + 1)'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HIT_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [1:0]          c_LIVES     = 2'(LIVES);

    logic [1:0]          r_state, w_state_nxt;
    logic [1:0]          r_lives, w_lives_nxt;
    logic [1:0]          r_level, w_level_nxt;
    logic                r_win, w_win_nxt;
    logic                r_blank, w_blank_nxt;
    logic                r_drift, w_drift_nxt;
    logic                r_lrst, w_lrst_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [c_HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [c_CNT_W:0]    w_period, w_period_m1;

    // Event decodes; crash outranks goal, and goal outranks the drift tick
    logic w_start_go, w_crash_go, w_goal_lvl, w_goal_win, w_hold_done, w_tick_due;
    assign w_start_go  = ((r_state == c_IDLE) || (r_state == c_OVER)) && start;
    assign w_crash_go  = (r_state == c_PLAY) && crash;
    assign w_goal_lvl  = (r_state == c_PLAY) && !crash && goal && (r_level != 2'd3);
    assign w_goal_win  = (r_state == c_PLAY) && !crash && goal && (r_level == 2'd3);
    assign w_hold_done = (r_state == c_HIT) && (r_hold == c_HOLD_LAST);
    assign w_tick_due  = ({1'b0, r_cnt} == w_period_m1);

    // Drift period for the current level
    always_comb begin
`ifdef FROG_SPEEDUP_EN
        w_period = c_BASE >> r_level;
        if (w_period < c_MINP) w_period = c_MINP;
`else
        w_period = c_BASE;
`endif
        w_period_m1 = w_period - c_PONE;
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_lives <= c_LIVES;
            r_level <= 2'd0;
            r_win   <= 1'b0;
            r_blank <= 1'b0;
            r_drift <= 1'b0;
            r_lrst  <= 1'b0;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_level <= w_level_nxt;
            r_win   <= w_win_nxt;
            r_blank <= w_blank_nxt;
            r_drift <= w_drift_nxt;
            r_lrst  <= w_lrst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_go) w_state_nxt = c_PLAY;
            c_PLAY: begin
                if (w_crash_go)      w_state_nxt = c_HIT;
                else if (w_goal_win) w_state_nxt = c_OVER;
            end
            c_HIT:   if (w_hold_done) w_state_nxt = (r_lives != 2'd0) ? c_PLAY : c_OVER;
            default: if (w_start_go) w_state_nxt = c_PLAY;
        endcase
    end

    // Next values of lives/level/flags/counters; counters rest at 0 outside PLAY/HIT
    always_comb begin
        w_lives_nxt = r_lives;
        w_level_nxt = r_level;
        w_win_nxt   = r_win;
        w_blank_nxt = r_blank;
        w_drift_nxt = 1'b0;
        w_lrst_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_hold_nxt  = '0;
        if (w_start_go) begin
            w_lives_nxt = c_LIVES;
            w_level_nxt = 2'd0;
            w_win_nxt   = 1'b0;
            w_blank_nxt = 1'b0;
            w_lrst_nxt  = 1'b1;
        end else if (w_crash_go) begin
            w_lives_nxt = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
            w_blank_nxt = 1'b1;
        end else if (w_goal_lvl) begin
            w_level_nxt = r_level + 2'd1;
            w_lrst_nxt  = 1'b1;
        end else if (w_goal_win) begin
            w_win_nxt = 1'b1;
        end else if (r_state == c_PLAY) begin
            if (w_tick_due) w_drift_nxt = 1'b1;
            else            w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end else if (r_state == c_HIT) begin
            if (w_hold_done) begin
                if (r_lives != 2'd0) begin
                    w_blank_nxt = 1'b0;
                    w_lrst_nxt  = 1'b1;
                end else begin
                    w_win_nxt = 1'b0;
                end
            end else begin
                w_hold_nxt = r_hold + c_HOLD_ONE;
            end
        end
    end

    assign drift_tick = r_drift;
    assign lane_reset = r_lrst;
    assign blank      = r_blank;
    assign lives      = r_lives;
    assign level      = r_level;
    assign state      = r_state;
    assign win        = r_win;

endmodule
`default_nettype wire

// File: tb/tb_frog_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frog_game_ctrl
//  Brief    : Directed self-checking bench for frog_game_ctrl (default
//             parameters). Expected drift periods follow FROG_SPEEDUP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frog_game_ctrl;

    localparam int c_P0 = 128;
`ifdef FROG_SPEEDUP_EN
    localparam int c_P1 = 64;
    localparam int c_P2 = 32;
`else
    localparam int c_P1 = 128;
    localparam int c_P2 = 128;
`endif
    localparam int c_HOLD = 16;
    localparam int c_BOUND = 400;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       crash = 1'b0;
    logic       goal  = 1'b0;
    logic       drift_tick, lane_reset, blank, win;
    logic [1:0] lives, level, state;

    int n_cmp = 0;
    int n_err = 0;

    frog_game_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .crash      (crash),
        .goal       (goal),
        .drift_tick (drift_tick),
        .lane_reset (lane_reset),
        .blank      (blank),
        .lives      (lives),
        .level      (level),
        .state      (state),
        .win        (win)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Count cycles until drift_tick is seen, bounded
    task automatic ticks_to_drift(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!drift_tick && n < c_BOUND);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
        n_cmp++; if (lives !== 2'd3) begin n_err++; $display("FAIL reset_lives got %0d want 3", lives); end
        n_cmp++; if ({level, win, blank, drift_tick, lane_reset} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got lvl=%0d win=%b blank=%b drift=%b lrst=%b want all 0",
                              level, win, blank, drift_tick, lane_reset);
        end
    endtask

    task automatic test_idle_ignore();
        crash = 1'b1; goal = 1'b1;
        step(); step();
        crash = 1'b0; goal = 1'b0;
        n_cmp++; if (state !== 2'b00 || lives !== 2'd3 || level !== 2'd0) begin
            n_err++; $display("FAIL idle_ignore got st=%0d lives=%0d lvl=%0d want 0/3/0", state, lives, level);
        end
    endtask

    task automatic test_start();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (state !== 2'b01 || lives !== 2'd3 || level !== 2'd0) begin
            n_err++; $display("FAIL start_regs got st=%0d lives=%0d lvl=%0d want 1/3/0", state, lives, level);
        end
        n_cmp++; if (lane_reset !== 1'b1 || drift_tick !== 1'b0) begin
            n_err++; $display("FAIL start_pulse got lrst=%b drift=%b want 1/0", lane_reset, drift_tick);
        end
        step();
        n_cmp++; if (lane_reset !== 1'b0) begin n_err++; $display("FAIL start_lrst_width got %b want 0", lane_reset); end
        ticks_to_drift(n);
        n_cmp++; if (n + 1 !== c_P0) begin n_err++; $display("FAIL first_drift_latency got %0d want %0d", n + 1, c_P0); end
    endtask

    task automatic test_drift_period();
        int n;
        step();
        n_cmp++; if (drift_tick !== 1'b0) begin n_err++; $display("FAIL drift_width got %b want 0", drift_tick); end
        ticks_to_drift(n);
        n_cmp++; if (n + 1 !== c_P0) begin n_err++; $display("FAIL drift_period_l0 got %0d want %0d", n + 1, c_P0); end
    endtask

    task automatic test_goal_level();
        int n;
        goal = 1'b1;
        step();
        goal = 1'b0;
        n_cmp++; if (state !== 2'b01 || level !== 2'd1 || lane_reset !== 1'b1 || drift_tick !== 1'b0) begin
            n_err++; $display("FAIL goal_l1 got st=%0d lvl=%0d lrst=%b drift=%b want 1/1/1/0",
                              state, level, lane_reset, drift_tick);
        end
        ticks_to_drift(n);
        n_cmp++; if (n !== c_P1) begin n_err++; $display("FAIL drift_period_l1 got %0d want %0d", n, c_P1); end
        goal = 1'b1;
        step();
        goal = 1'b0;
        n_cmp++; if (level !== 2'd2 || lane_reset !== 1'b1) begin
            n_err++; $display("FAIL goal_l2 got lvl=%0d lrst=%b want 2/1", level, lane_reset);
        end
        ticks_to_drift(n);
        n_cmp++; if (n !== c_P2) begin n_err++; $display("FAIL drift_period_l2 got %0d want %0d", n, c_P2); end
        ticks_to_drift(n);
        n_cmp++; if (n !== c_P2) begin n_err++; $display("FAIL drift_period_l2_again got %0d want %0d", n, c_P2); end
    endtask

    task automatic test_crash_goal();
        int n;
        crash = 1'b1; goal = 1'b1;
        step();
        n_cmp++; if (state !== 2'b10 || lives !== 2'd2 || level !== 2'd2 || blank !== 1'b1 || lane_reset !== 1'b0) begin
            n_err++; $display("FAIL crash_goal got st=%0d lives=%0d lvl=%0d blank=%b lrst=%b want 2/2/2/1/0",
                              state, lives, level, blank, lane_reset);
        end
        n = 1;
        while (state == 2'b10 && n < 40) begin
            step();
            if (state == 2'b10) n++;
        end
        crash = 1'b0; goal = 1'b0;
        n_cmp++; if (n !== c_HOLD) begin n_err++; $display("FAIL hit_blank_cycles got %0d want %0d", n, c_HOLD); end
        n_cmp++; if (state !== 2'b01 || blank !== 1'b0 || lane_reset !== 1'b1 || lives !== 2'd2 || level !== 2'd2) begin
            n_err++; $display("FAIL hit_exit got st=%0d blank=%b lrst=%b lives=%0d lvl=%0d want 1/0/1/2/2",
                              state, blank, lane_reset, lives, level);
        end
    endtask

    task automatic test_win();
        goal = 1'b1;
        step();
        n_cmp++; if (level !== 2'd3 || state !== 2'b01) begin
            n_err++; $display("FAIL goal_l3 got lvl=%0d st=%0d want 3/1", level, state);
        end
        step();
        goal = 1'b0;
        n_cmp++; if (state !== 2'b11 || win !== 1'b1 || level !== 2'd3 || lane_reset !== 1'b0) begin
            n_err++; $display("FAIL goal_win got st=%0d win=%b lvl=%0d lrst=%b want 3/1/3/0",
                              state, win, level, lane_reset);
        end
        crash = 1'b1; goal = 1'b1;
        step(); step();
        crash = 1'b0; goal = 1'b0;
        n_cmp++; if (state !== 2'b11 || lives !== 2'd2 || win !== 1'b1) begin
            n_err++; $display("FAIL over_ignore got st=%0d lives=%0d win=%b want 3/2/1", state, lives, win);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (state !== 2'b01 || lives !== 2'd3 || level !== 2'd0 || win !== 1'b0 || lane_reset !== 1'b1) begin
            n_err++; $display("FAIL over_restart got st=%0d lives=%0d lvl=%0d win=%b lrst=%b want 1/3/0/0/1",
                              state, lives, level, win, lane_reset);
        end
    endtask

    task automatic test_three_crashes();
        int n;
        for (int k = 1; k <= 3; k++) begin
            crash = 1'b1;
            step();
            crash = 1'b0;
            n_cmp++; if (state !== 2'b10 || lives !== 2'(3 - k)) begin
                n_err++; $display("FAIL crash_%0d got st=%0d lives=%0d want 2/%0d", k, state, lives, 3 - k);
            end
            n = 0;
            while (state == 2'b10 && n < 40) begin step(); n++; end
        end
        n_cmp++; if (state !== 2'b11 || lives !== 2'd0 || win !== 1'b0 || blank !== 1'b1 || lane_reset !== 1'b0) begin
            n_err++; $display("FAIL game_over got st=%0d lives=%0d win=%b blank=%b lrst=%b want 3/0/0/1/0",
                              state, lives, win, blank, lane_reset);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (state !== 2'b01 || lives !== 2'd3 || blank !== 1'b0) begin
            n_err++; $display("FAIL restart_after_over got st=%0d lives=%0d blank=%b want 1/3/0", state, lives, blank);
        end
    endtask

    task automatic test_reset_mid_hit();
        crash = 1'b1;
        step();
        crash = 1'b0;
        step(); step(); step();
        reset = 1'b1; start = 1'b1; crash = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; crash = 1'b0;
        n_cmp++; if (state !== 2'b00 || lives !== 2'd3 || level !== 2'd0 || {win, blank, drift_tick, lane_reset} !== 4'b0) begin
            n_err++; $display("FAIL reset_mid_hit got st=%0d lives=%0d lvl=%0d win=%b blank=%b drift=%b lrst=%b want 0/3/0/0/0/0/0",
                              state, lives, level, win, blank, drift_tick, lane_reset);
        end
    endtask

    task automatic test_reset_mid_tick();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (state !== 2'b00 || drift_tick !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_tick got st=%0d drift=%b want 0/0", state, drift_tick);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        ticks_to_drift(n);
        n_cmp++; if (n !== c_P0) begin n_err++; $display("FAIL drift_after_reset got %0d want %0d", n, c_P0); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_start();
        test_drift_period();
        test_goal_level();
        test_crash_goal();
        test_win();
        test_three_crashes();
        test_reset_mid_hit();
        test_reset_mid_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
